// File: rtl/inst_fetch.sv
// Instruction fetch + IF/ID register: drives the ROM address from the PC and registers {pc, rom_inst} for decode with 1-cycle latency.
// Stall holds the PC and IF/ID. Flush overrides stall. A branch seen during a stall is parked and applied on release.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  input  logic        branch_flag,
  input  logic [31:0] branch_target,
  output logic        rom_re,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_inst,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic        id_valid
);

  localparam logic CHIP_ENABLE  = 1'b1;
  localparam logic CHIP_DISABLE = 1'b0;

  typedef enum logic {
    S_BOOT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic        r_pend_valid;
  logic [31:0] r_pend_target;
  logic [31:0] r_id_pc;
  logic [31:0] r_id_inst;
  logic        r_id_valid;

  state_t      w_state_nxt;
  logic [31:0] w_pc_nxt;
  logic        w_pend_valid_nxt;
  logic [31:0] w_pend_target_nxt;
  logic [31:0] w_id_pc_nxt;
  logic [31:0] w_id_inst_nxt;
  logic        w_id_valid_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_BOOT;
      r_pc          <= RESET_PC;
      r_pend_valid  <= 1'b0;
      r_pend_target <= 32'h0000_0000;
      r_id_pc       <= 32'h0000_0000;
      r_id_inst     <= NOP_INST;
      r_id_valid    <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_pend_valid  <= w_pend_valid_nxt;
      r_pend_target <= w_pend_target_nxt;
      r_id_pc       <= w_id_pc_nxt;
      r_id_inst     <= w_id_inst_nxt;
      r_id_valid    <= w_id_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_pc_nxt          = r_pc;
    w_pend_valid_nxt  = r_pend_valid;
    w_pend_target_nxt = r_pend_target;
    w_id_pc_nxt       = r_id_pc;
    w_id_inst_nxt     = r_id_inst;
    w_id_valid_nxt    = r_id_valid;

    unique case (r_state)
      // Nothing was fetched while the ROM was disabled, so IF/ID stays a bubble.
      S_BOOT: w_state_nxt = S_RUN;
      S_RUN: begin
        if (flush) begin
          w_pc_nxt         = flush_pc;
          w_pend_valid_nxt = 1'b0;
          w_id_pc_nxt      = 32'h0000_0000;
          w_id_inst_nxt    = NOP_INST;
          w_id_valid_nxt   = 1'b0;
        end else if (stall) begin
          if (branch_flag) begin
            w_pend_valid_nxt  = 1'b1;
            w_pend_target_nxt = branch_target;
          end
        end else begin
          // Current fetch is the delay slot of any redirect and is always kept.
          w_id_pc_nxt      = r_pc;
          w_id_inst_nxt    = rom_inst;
          w_id_valid_nxt   = 1'b1;
          w_pend_valid_nxt = 1'b0;
          if (branch_flag) begin
            w_pc_nxt = branch_target;
          end else if (r_pend_valid) begin
            w_pc_nxt = r_pend_target;
          end else begin
            w_pc_nxt = r_pc + 32'd4;
          end
        end
      end
      default: w_state_nxt = S_BOOT;
    endcase
  end

  assign rom_re   = (r_state == S_RUN) ? CHIP_ENABLE : CHIP_DISABLE;
  assign rom_addr = r_pc;
  assign id_pc    = r_id_pc;
  assign id_inst  = r_id_inst;
  assign id_valid = r_id_valid;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed test-plan scenarios plus randomized stall/flush/branch traffic against a cycle model.
module tb_inst_fetch;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] flush_pc = 32'h0;
  logic        branch_flag = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        rom_re;
  logic [31:0] rom_addr;
  logic [31:0] rom_inst;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_valid;

  int n_err = 0;
  int n_chk = 0;

  inst_fetch #(.RESET_PC(RST_PC), .NOP_INST(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .flush_pc(flush_pc),
    .branch_flag(branch_flag), .branch_target(branch_target), .rom_re(rom_re),
    .rom_addr(rom_addr), .rom_inst(rom_inst), .id_pc(id_pc), .id_inst(id_inst),
    .id_valid(id_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    case (a)
      32'h0: return 32'h11;
      32'h4: return 32'h22;
      32'h8: return 32'h33;
      default: return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0000;
    endcase
  endfunction

  assign rom_inst = rom_word(rom_addr);

  // Reference model: what fetch address and IF/ID contents the rules demand.
  logic        m_run;
  logic [31:0] m_pc;
  logic        m_pend;
  logic [31:0] m_tgt;
  logic [31:0] m_idpc;
  logic [31:0] m_idinst;
  logic        m_idv;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run <= 1'b0; m_pc <= RST_PC; m_pend <= 1'b0; m_tgt <= 32'h0;
      m_idpc <= 32'h0; m_idinst <= NOP; m_idv <= 1'b0;
    end else if (!m_run) begin
      m_run <= 1'b1;
    end else if (flush) begin
      m_pc <= flush_pc; m_pend <= 1'b0;
      m_idpc <= 32'h0; m_idinst <= NOP; m_idv <= 1'b0;
    end else if (stall) begin
      if (branch_flag) begin
        m_pend <= 1'b1; m_tgt <= branch_target;
      end
    end else begin
      m_idpc <= m_pc; m_idinst <= rom_word(m_pc); m_idv <= 1'b1;
      m_pend <= 1'b0;
      m_pc <= branch_flag ? branch_target : (m_pend ? m_tgt : m_pc + 32'd4);
    end
  end

  always @(negedge clk) begin
    n_chk++;
    if (rom_re !== m_run || rom_addr !== m_pc || id_valid !== m_idv ||
        id_inst !== m_idinst || (m_idv && id_pc !== m_idpc)) begin
      n_err++;
      $display("FAIL model t=%0t: got re=%b addr=%h v=%b pc=%h inst=%h want re=%b addr=%h v=%b pc=%h inst=%h",
               $time, rom_re, rom_addr, id_valid, id_pc, id_inst,
               m_run, m_pc, m_idv, m_idpc, m_idinst);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step(input logic s, input logic f, input logic [31:0] fp,
                      input logic b, input logic [31:0] t);
    stall = s; flush = f; flush_pc = fp; branch_flag = b; branch_target = t;
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  initial begin
    logic s, f, b;
    logic [31:0] fp, t;

    repeat (3) @(negedge clk);
    chk("reset rom_re", {31'b0, rom_re}, 32'h0);
    chk("reset id_valid", {31'b0, id_valid}, 32'h0);
    rst_n = 1'b1;
    #1;
    chk("release rom_re", {31'b0, rom_re}, 32'h0);
    chk("release id_valid", {31'b0, id_valid}, 32'h0);
    idle();
    chk("boot rom_re", {31'b0, rom_re}, 32'h1);
    chk("boot id_valid", {31'b0, id_valid}, 32'h0);
    idle();
    chk("first inst", id_inst, 32'h11);
    chk("first pc", id_pc, 32'h0);
    idle();
    chk("second inst", id_inst, 32'h22);
    chk("third addr", rom_addr, 32'h8);

    step(1'b0, 1'b0, 32'h0, 1'b1, 32'h40);
    chk("branch addr", rom_addr, 32'h40);
    chk("delay slot inst", id_inst, 32'h33);
    chk("delay slot valid", {31'b0, id_valid}, 32'h1);
    idle();
    chk("branch target in id", id_pc, 32'h40);

    step(1'b0, 1'b1, 32'hC, 1'b0, 32'h0);
    chk("flush addr", rom_addr, 32'hC);
    chk("flush bubble", {31'b0, id_valid}, 32'h0);
    idle();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      chk("stall addr", rom_addr, 32'h10);
      chk("stall id_pc", id_pc, 32'hC);
    end
    idle();
    chk("post-stall addr", rom_addr, 32'h14);

    step(1'b1, 1'b0, 32'h0, 1'b1, 32'h80);
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    idle();
    chk("stalled branch addr", rom_addr, 32'h80);
    chk("stalled branch slot", id_pc, 32'h14);
    idle();
    chk("stalled branch target", id_pc, 32'h80);
    chk("after target addr", rom_addr, 32'h84);

    step(1'b1, 1'b0, 32'h0, 1'b1, 32'h100);
    step(1'b1, 1'b1, 32'h180, 1'b1, 32'h200);
    chk("flush prio addr", rom_addr, 32'h180);
    chk("flush prio bubble", {31'b0, id_valid}, 32'h0);
    idle();
    chk("pending discarded", rom_addr, 32'h184);

    step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
    idle();
    chk("wrap addr", rom_addr, 32'h0);
    chk("wrap id_pc", id_pc, 32'hFFFF_FFFC);

    for (int i = 0; i < 3000; i++) begin
      s = ($urandom % 4) == 0;
      f = ($urandom % 16) == 0;
      b = ($urandom % 6) == 0;
      if (m_pend && !s) b = 1'b0;
      fp = (($urandom % 8) == 0) ? (32'hFFFF_FFF0 | ($urandom % 16)) : ($urandom & 32'h0000_FFFC);
      t  = (($urandom % 8) == 0) ? $urandom : ($urandom & 32'h0000_FFFC);
      step(s, f, fp, b, t);
    end

    stall = 1'b0; flush = 1'b0; branch_flag = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async rst rom_re", {31'b0, rom_re}, 32'h0);
    chk("async rst addr", rom_addr, RST_PC);
    chk("async rst valid", {31'b0, id_valid}, 32'h0);
    chk("async rst inst", id_inst, NOP);
    chk("async rst id_pc", id_pc, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) idle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
